ring_ready_tracker: RTL and testbench

Parametrised occupancy tracker for the circular line buffers in the convolution engine. It owns the write and read pointers with their round (wrap) bits and accepts single-entry pushes and multi-entry pops, so a sliding window can release a whole stride at once. It publishes a registered per-slot ready mask, the occupancy count, and full/empty/error status. Read-side logic uses it to decide which buffer slots may be consumed.

---
 rtl/ring_ready_tracker_pkg.sv | 27 ++
 rtl/ring_ready_mask.sv | 25 ++
 rtl/ring_ready_tracker.sv | 95 +++++++++
 tb/tb_ring_ready_tracker.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ring_ready_tracker_pkg.sv
// Shared definitions for the ring_ready_tracker family: width helper,
// depth sanity check and the default pointer type.
package ring_ready_tracker_pkg;

    // Ceiling log2 for elaboration-time width derivation.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // A ring depth is usable only if it is a power of two and at least 2.
    function automatic bit depth_is_valid(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    localparam int DEFAULT_DEPTH  = 8;
    localparam int DEFAULT_ADDR_W = clog2(DEFAULT_DEPTH);

    // Pointer for the default depth: MSB is the round bit, low bits the slot.
    // Parametrised instances declare the same shape locally from ADDR_W.
    typedef logic [DEFAULT_ADDR_W:0] ptr_t;

endpackage

// File: rtl/ring_ready_mask.sv
// Combinational slot-ready mask: marks the count slots starting at r_addr,
// wrapping circularly within DEPTH bits.
module ring_ready_mask
    import ring_ready_tracker_pkg::*;
#(
    parameter  int DEPTH  = 8,
    localparam int ADDR_W = clog2(DEPTH)
) (
    input  logic [ADDR_W:0]   count,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [DEPTH-1:0]  ready
);

    logic [DEPTH-1:0] span;

    // Low-count-bits pattern rotated left by r_addr.
    always_comb begin
        // NOTE: every always_comb output gets an unconditional assignment, so no latch can be inferred.
        // The DEPTH+1-bit shift lets count==DEPTH produce all ones.
        span  = DEPTH'(((DEPTH + 1)'(1) << count) - (DEPTH + 1)'(1));
        // The upper half of the doubled pattern after a left shift is the circular rotate.
        ready = DEPTH'(({span, span} << r_addr) >> DEPTH);
    end

endmodule

// File: rtl/ring_ready_tracker.sv
// Occupancy tracker for circular line buffers: owns write/read pointers with
// round bits, accepts one push and a multi-entry pop per cycle, and publishes
// registered ready mask, count and full/empty/sticky error status.
module ring_ready_tracker
    import ring_ready_tracker_pkg::*;
#(
    parameter  int DEPTH  = 8,
    localparam int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [ADDR_W:0]   pop_n,
    input  logic              err_clr,
    output logic [ADDR_W-1:0] w_addr,
    output logic [ADDR_W-1:0] r_addr,
    output logic              w_round,
    output logic              r_round,
    output logic [ADDR_W:0]   count,
    output logic [DEPTH-1:0]  ready,
    output logic              full,
    output logic              empty,
    output logic              ovf,
    output logic              udf
);

    if (!depth_is_valid(DEPTH)) begin : g_bad_depth
        $error("ring_ready_tracker: DEPTH must be a power of two and at least 2");
    end

    typedef logic [ADDR_W:0] tptr_t;

    localparam tptr_t DEPTH_P = tptr_t'(DEPTH);

    tptr_t            wptr_q, rptr_q;
    tptr_t            wptr_d, rptr_d;
    tptr_t            cur_count, accepted_pop, count_d;
    logic             pop_ok, push_ok;
    logic             ovf_d, udf_d;
    logic [DEPTH-1:0] ready_d;

    // Legality and next-state pointers; the pop is judged on the pre-edge
    // count and the push on what is left after the accepted pop.
    always_comb begin
        cur_count    = wptr_q - rptr_q;
        pop_ok       = (pop_n <= cur_count);
        accepted_pop = pop_ok ? pop_n : '0;
        push_ok      = push && ((cur_count - accepted_pop) < DEPTH_P);
        rptr_d       = rptr_q + accepted_pop;
        wptr_d       = wptr_q + tptr_t'(push_ok);
        // Modulo 2^(ADDR_W+1) difference stays exact across differing rounds.
        count_d      = wptr_d - rptr_d;
        // Clear wins over a same-cycle set.
        udf_d        = err_clr ? 1'b0 : (udf | !pop_ok);
        ovf_d        = err_clr ? 1'b0 : (ovf | (push && !push_ok));
    end

    ring_ready_mask #(
        .DEPTH  (DEPTH)
    ) u_mask (
        .count  (count_d),
        .r_addr (rptr_d[ADDR_W-1:0]),
        .ready  (ready_d)
    );

    // Pointer and status registers, all loaded from the same next-state values.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            count  <= '0;
            ready  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            count  <= count_d;
            ready  <= ready_d;
            full   <= (count_d == DEPTH_P);
            empty  <= (count_d == '0);
            ovf    <= ovf_d;
            udf    <= udf_d;
        end
    end

    assign w_addr  = wptr_q[ADDR_W-1:0];
    assign w_round = wptr_q[ADDR_W];
    assign r_addr  = rptr_q[ADDR_W-1:0];
    assign r_round = rptr_q[ADDR_W];

endmodule

// File: tb/tb_ring_ready_tracker.sv
// Directed vector table plus a queue-model random run for ring_ready_tracker.
module tb_ring_ready_tracker;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              push;
    logic [ADDR_W:0]   pop_n;
    logic              err_clr;
    logic [ADDR_W-1:0] w_addr, r_addr;
    logic              w_round, r_round;
    logic [ADDR_W:0]   count;
    logic [DEPTH-1:0]  ready;
    logic              full, empty, ovf, udf;

    int n_vec  = 0;
    int n_miss = 0;

    ring_ready_tracker #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop_n   (pop_n),
        .err_clr (err_clr),
        .w_addr  (w_addr),
        .r_addr  (r_addr),
        .w_round (w_round),
        .r_round (r_round),
        .count   (count),
        .ready   (ready),
        .full    (full),
        .empty   (empty),
        .ovf     (ovf),
        .udf     (udf)
    );

    always #5 clk = ~clk;

    // Field order: count, ready, w_addr, w_round, r_addr, r_round, full, empty, ovf, udf
    typedef struct {
        bit          rst;
        bit          push;
        int          pop;
        bit          clr;
        logic [23:0] exp;
    } vec_t;

    function automatic logic [23:0] pack_exp(int c, int rdy, int wa, bit wr, int ra, bit rr,
                                             bit f, bit e, bit o, bit u);
        return {4'(c), 8'(rdy), 3'(wa), wr, 3'(ra), rr, f, e, o, u};
    endfunction

    function automatic vec_t mk(bit rst, bit ps, int pop, bit clr, int c, int rdy, int wa, bit wr,
                                int ra, bit rr, bit f, bit e, bit o, bit u);
        vec_t v;
        v.rst  = rst;
        v.push = ps;
        v.pop  = pop;
        v.clr  = clr;
        v.exp  = pack_exp(c, rdy, wa, wr, ra, rr, f, e, o, u);
        return v;
    endfunction

    function automatic logic [23:0] actual();
        return {count, ready, w_addr, w_round, r_addr, r_round, full, empty, ovf, udf};
    endfunction

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (cnt,rdy,wa,wr,ra,rr,f,e,o,u)", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input bit rst, input bit ps, input int pop, input bit clr);
        reset   = rst;
        push    = ps;
        pop_n   = 4'(pop);
        err_clr = clr;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];

    // Reference queue model state
    int q[$];
    int m_wp, m_rp;
    bit m_ovf, m_udf;

    task automatic model_step(input bit rst, input bit ps, input int pop, input bit clr);
        int cnt;
        if (rst) begin
            q.delete();
            m_wp  = 0;
            m_rp  = 0;
            m_ovf = 0;
            m_udf = 0;
        end else begin
            cnt = q.size();
            if (pop <= cnt) begin
                for (int k = 0; k < pop; k++) void'(q.pop_front());
                m_rp = (m_rp + pop) % 16;
            end else begin
                m_udf = 1;
            end
            if (ps) begin
                if (q.size() < DEPTH) begin
                    q.push_back(m_wp % DEPTH);
                    m_wp = (m_wp + 1) % 16;
                end else begin
                    m_ovf = 1;
                end
            end
            if (clr) begin
                m_ovf = 0;
                m_udf = 0;
            end
        end
    endtask

    function automatic logic [23:0] model_exp();
        int rdy;
        rdy = 0;
        foreach (q[k]) rdy = rdy | (1 << q[k]);
        return pack_exp(q.size(), rdy, m_wp % 8, 1'(m_wp / 8), m_rp % 8, 1'(m_rp / 8),
                        q.size() == DEPTH, q.size() == 0, m_ovf, m_udf);
    endfunction

    initial begin
        reset   = 1'b1;
        push    = 1'b0;
        pop_n   = '0;
        err_clr = 1'b0;

        //            rst ps pop clr  cnt rdy    wa wr ra rr f  e  o  u
        tbl.push_back(mk(1, 0, 0, 0,   0, 'h00, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,   0, 'h00, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,   1, 'h01, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,   2, 'h03, 2, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,   3, 'h07, 3, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,   4, 'h0F, 4, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,   5, 'h1F, 5, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,   6, 'h3F, 6, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,   7, 'h7F, 7, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,   8, 'hFF, 0, 1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,   8, 'hFF, 0, 1, 0, 0, 1, 0, 1, 0)); // push on full
        tbl.push_back(mk(0, 0, 0, 1,   8, 'hFF, 0, 1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 3, 0,   5, 'hF8, 0, 1, 3, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,   6, 'hF9, 1, 1, 3, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,   7, 'hFB, 2, 1, 3, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 3, 0,   4, 'hC3, 2, 1, 6, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,   5, 'hC7, 3, 1, 6, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5, 0,   1, 'h08, 4, 1, 3, 1, 0, 0, 0, 0)); // push + pop 5
        tbl.push_back(mk(0, 1, 0, 0,   2, 'h18, 5, 1, 3, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,   3, 'h38, 6, 1, 3, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,   4, 'h78, 7, 1, 3, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,   5, 'hF8, 0, 0, 3, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,   6, 'hF9, 1, 0, 3, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,   7, 'hFB, 2, 0, 3, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,   8, 'hFF, 3, 0, 3, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0,   8, 'hFF, 4, 0, 4, 1, 1, 0, 0, 0)); // full, push + pop 1
        tbl.push_back(mk(0, 0, 6, 0,   2, 'h0C, 4, 0, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 3, 0,   2, 'h0C, 4, 0, 2, 0, 0, 0, 0, 1)); // underflow
        tbl.push_back(mk(0, 0, 3, 1,   2, 'h0C, 4, 0, 2, 0, 0, 0, 0, 0)); // clr beats set
        tbl.push_back(mk(0, 0, 9, 0,   2, 'h0C, 4, 0, 2, 0, 0, 0, 0, 1)); // pop_n > DEPTH
        tbl.push_back(mk(0, 0, 2, 0,   0, 'h00, 4, 0, 4, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1,   0, 'h00, 4, 0, 4, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0,   1, 'h10, 5, 0, 4, 0, 0, 0, 0, 1)); // empty push + pop 1
        tbl.push_back(mk(1, 1, 1, 0,   0, 'h00, 0, 0, 0, 0, 0, 1, 0, 0)); // reset mid-stream
        tbl.push_back(mk(0, 0, 0, 0,   0, 'h00, 0, 0, 0, 0, 0, 1, 0, 0));

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].push, tbl[i].pop, tbl[i].clr);
            check($sformatf("vec[%0d]", i), actual(), tbl[i].exp);
        end

        // Random run against the queue model; DUT is in reset state here.
        model_step(1'b1, 1'b0, 0, 1'b0);
        for (int cyc = 0; cyc < 10000; cyc++) begin
            bit rst, ps, clr;
            int pop, r;
            bit fill_phase;
            fill_phase = ((cyc / 200) % 2) == 0;
            rst = (cyc == 5000) || (cyc == 8000);
            ps  = fill_phase ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 40);
            r   = $urandom_range(0, 99);
            if (fill_phase) pop = (r < 75) ? 0 : (r < 97) ? $urandom_range(1, 3) : $urandom_range(9, 15);
            else            pop = (r < 35) ? 0 : (r < 85) ? $urandom_range(1, 3)
                                : (r < 96) ? $urandom_range(4, 8) : $urandom_range(9, 15);
            clr = ($urandom_range(0, 99) < 3);
            step(rst, ps, pop, clr);
            model_step(rst, ps, pop, clr);
            check($sformatf("rand[%0d]", cyc), actual(), model_exp());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
